seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for a DIGITS-wide common-segment 7-segment display.

---
 rtl/seven_seg_scan_driver_if.sv | 38 +++
 rtl/seven_seg_scan_driver.sv | 137 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Purpose: groups the data/control inputs and display pin outputs of the
//          seven-segment scan driver into one bundle.
// Ports (members):
//   digits_i      BCD digits, digit k = [4k+3:4k]
//   dp_i          decimal point per digit, 1 = lit
//   load_i        1-cycle strobe capturing digits_i/dp_i
//   blank_lz_i    1 = blank leading zeros
//   blink_mask_i  1 = digit blinks
//   enable_i      0 = display dark
//   seg_o         {a,b,c,d,e,f,g}, active low
//   dp_o          decimal point, active low
//   an_o          one-hot anode select
//   frame_o       1-cycle pulse at each frame start
// Modports: master = producer of digits / consumer of pins, slave = driver.
interface seven_seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] digits_i;
    logic [DIGITS-1:0]   dp_i;
    logic                load_i;
    logic                blank_lz_i;
    logic [DIGITS-1:0]   blink_mask_i;
    logic                enable_i;
    logic [6:0]          seg_o;
    logic                dp_o;
    logic [DIGITS-1:0]   an_o;
    logic                frame_o;

    modport master (
        output digits_i, dp_i, load_i, blank_lz_i, blink_mask_i, enable_i,
        input  seg_o, dp_o, an_o, frame_o
    );

    modport slave (
        input  digits_i, dp_i, load_i, blank_lz_i, blink_mask_i, enable_i,
        output seg_o, dp_o, an_o, frame_o
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Purpose: time-multiplexed driver for a DIGITS-wide 7-segment display.
//          Loaded digits sit in a shadow register and move to the active
//          register only at frame boundaries, so a scan never tears. Adds
//          leading-zero blanking, per-digit blink and anode dead time.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    seven_seg_scan_driver_if.slave (digit inputs, display pins)
module seven_seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int DEAD_CYC   = 8,
    parameter int BLINK_HZ   = 2,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW   = $clog2(DIGITS);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    if (DIV <= DEAD_CYC + 1) begin : g_div_chk
        $error("seven_seg_scan_driver: DIV must exceed DEAD_CYC+1");
    end
    if (DIGITS < 2) begin : g_dig_chk
        $error("seven_seg_scan_driver: DIGITS must be >= 2");
    end

    logic [CW-1:0]            cyc;
    logic [IW-1:0]            idx;
    logic [BW-1:0]            bcnt;
    logic                     blink_on;
    logic [DIGITS-1:0][3:0]   shadow_dig, active_dig;
    logic [DIGITS-1:0]        shadow_dp, active_dp;
    logic                     pending;

    logic                     slot_end, wrap;
    logic [DIGITS-1:0]        lz, sel, an_val;
    logic                     zero_above, blink_off, hide;
    logic [3:0]               cur;

    assign slot_end = (cyc == CW'(DIV - 1));
    assign wrap     = slot_end && (idx == IW'(DIGITS - 1));
    assign cur      = active_dig[idx];

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // lz[k]: digits k..DIGITS-1 are all zero; digit 0 is never a leading zero.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (active_dig[k] == 4'd0);
            lz[k]      = zero_above;
        end
    end

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
        an_val   = (AN_ACT_LOW != 0) ? ~sel : sel;
    end

    assign blink_off = !blink_on && bus.blink_mask_i[idx];
    assign hide      = blink_off || (bus.blank_lz_i && lz[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc         <= '0;
            idx         <= '0;
            bcnt        <= '0;
            blink_on    <= 1'b1;
            shadow_dig  <= '0;
            shadow_dp   <= '0;
            active_dig  <= '0;
            active_dp   <= '0;
            pending     <= 1'b0;
            bus.seg_o   <= 7'b1111111;
            bus.dp_o    <= 1'b1;
            bus.an_o    <= AN_OFF;
            bus.frame_o <= 1'b0;
        end else begin
            cyc <= slot_end ? '0 : cyc + CW'(1);
            if (slot_end)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

            if (bcnt == BW'(HALF - 1)) begin
                bcnt     <= '0;
                blink_on <= !blink_on;
            end else begin
                bcnt <= bcnt + BW'(1);
            end

            if (bus.load_i) begin
                shadow_dig <= bus.digits_i;
                shadow_dp  <= bus.dp_i;
            end
            // A load coinciding with the wrap bypasses the shadow entirely.
            if (bus.load_i && wrap) begin
                active_dig <= bus.digits_i;
                active_dp  <= bus.dp_i;
                pending    <= 1'b0;
            end else if (bus.load_i) begin
                pending    <= 1'b1;
            end else if (wrap && pending) begin
                active_dig <= shadow_dig;
                active_dp  <= shadow_dp;
                pending    <= 1'b0;
            end

            bus.frame_o <= wrap;
            bus.an_o    <= (bus.enable_i && cyc >= CW'(DEAD_CYC)) ? an_val : AN_OFF;
            bus.seg_o   <= hide ? 7'b1111111 : decode(cur);
            bus.dp_o    <= blink_off ? 1'b1 : ~active_dp[idx];
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;
    localparam int DIGITS = 4;
    localparam int DIV    = 10;
    localparam int FRAME  = 40;
    localparam int HALF   = 100;
    localparam int DEAD   = 2;

    logic clk;
    logic rst_n;
    int   total, bad, n;

    // load history: edge number, digits, dp
    int          ld_n[$];
    logic [15:0] ld_dig[$];
    logic [3:0]  ld_dp[$];

    seven_seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_scan_driver #(
        .DIGITS(DIGITS), .CLK_HZ(1000), .SCAN_HZ(100), .DEAD_CYC(DEAD),
        .BLINK_HZ(5), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: seg_ref = 7'b0000001;  4'd1: seg_ref = 7'b1001111;
            4'd2: seg_ref = 7'b0010010;  4'd3: seg_ref = 7'b0000110;
            4'd4: seg_ref = 7'b1001100;  4'd5: seg_ref = 7'b0100100;
            4'd6: seg_ref = 7'b0100000;  4'd7: seg_ref = 7'b0001111;
            4'd8: seg_ref = 7'b0000000;  4'd9: seg_ref = 7'b0000100;
            default: seg_ref = 7'b1111111;
        endcase
    endfunction

    // Digits visible after m edges: last load at or before the latest frame edge.
    task automatic shown_at(input int m, output logic [15:0] d, output logic [3:0] p);
        int  f;
        bit  found;
        f = (m / FRAME) * FRAME;
        d = '0; p = '0; found = 0;
        for (int i = ld_n.size() - 1; i >= 0; i--) begin
            if (!found && ld_n[i] <= f) begin
                d = ld_dig[i]; p = ld_dp[i]; found = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_seg"},   {25'd0, bus.seg_o},   32'h7f);
        chk({tag, "_dp"},    {31'd0, bus.dp_o},    32'h1);
        chk({tag, "_an"},    {28'd0, bus.an_o},    32'hf);
        chk({tag, "_frame"}, {31'd0, bus.frame_o}, 32'h0);
    endtask

    task automatic tick();
        logic [15:0] d;
        logic [3:0]  p, e_an;
        logic [6:0]  e_seg;
        logic        ph, boff, hide, zero, e_dp, e_fr;
        int          m, cyc, idx;
        @(posedge clk);
        n++;
        if (bus.load_i) begin
            ld_n.push_back(n); ld_dig.push_back(bus.digits_i); ld_dp.push_back(bus.dp_i);
        end
        m   = n - 1;
        shown_at(m, d, p);
        cyc = m % DIV;
        idx = (m / DIV) % DIGITS;
        ph  = ((m / HALF) % 2) == 0;
        zero = 1'b1;
        for (int k = idx; k < DIGITS; k++)
            if (d[4*k +: 4] != 4'd0) zero = 1'b0;
        boff  = !ph && bus.blink_mask_i[idx];
        hide  = boff || (bus.blank_lz_i && idx >= 1 && zero);
        e_seg = hide ? 7'b1111111 : seg_ref(d[4*idx +: 4]);
        e_dp  = boff ? 1'b1 : !p[idx];
        e_an  = (bus.enable_i && cyc >= DEAD) ? ~(4'b0001 << idx) : 4'b1111;
        e_fr  = (n % FRAME) == 0;
        #1;
        chk("seg",   {25'd0, bus.seg_o},   {25'd0, e_seg});
        chk("dp",    {31'd0, bus.dp_o},    {31'd0, e_dp});
        chk("an",    {28'd0, bus.an_o},    {28'd0, e_an});
        chk("frame", {31'd0, bus.frame_o}, {31'd0, e_fr});
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic run_to(input int phase);
        int guard;
        guard = 0;
        while ((n % FRAME) != phase && guard < FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        bus.digits_i = d; bus.dp_i = p; bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
    endtask

    initial begin
        int          first_fr;
        logic [15:0] rd;
        total = 0; bad = 0; n = 0;
        rst_n = 1'b1;
        bus.digits_i = '0; bus.dp_i = '0; bus.load_i = 1'b0; bus.blank_lz_i = 1'b0;
        bus.blink_mask_i = '0; bus.enable_i = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: load 1234; first frame still shows zeros, next frame shows digits
        load(16'h1234, 4'b0000);
        run(1);
        chk("t1_first_frame_seg", {25'd0, bus.seg_o}, 32'b0000001);
        while (n < 43) tick();
        chk("t1_slot0_seg", {25'd0, bus.seg_o}, 32'b1001100);
        chk("t1_slot0_an",  {28'd0, bus.an_o},  32'b1110);
        run(50);

        // 2: leading-zero blanking
        bus.blank_lz_i = 1'b1;
        load(16'h0050, 4'b1010);
        run(90);
        load(16'h0000, 4'b0100);
        run(90);

        // 3: blink digit 0 across several phases
        bus.blank_lz_i = 1'b0;
        bus.blink_mask_i = 4'b0001;
        load(16'h0008, 4'b0001);
        run(420);
        bus.blink_mask_i = 4'b0000;

        // 4: load timing relative to frame boundaries
        run_to(14);
        load(16'h9999, 4'b0000);
        run(60);
        run_to(39);
        load(16'h4321, 4'b1000);
        run(45);
        run_to(5);
        load(16'h1111, 4'b0001);
        run(3);
        load(16'h5678, 4'b0010);
        run(80);

        // 5: non-BCD digit, enable gating mid-slot
        load(16'h00A0, 4'b0000);
        run(60);
        run_to(24);
        bus.enable_i = 1'b0;
        tick();
        chk("t5_an_off", {28'd0, bus.an_o}, 32'hf);
        run(23);
        bus.enable_i = 1'b1;
        run(45);

        // randomized mix
        for (int i = 0; i < 600; i++) begin
            rd = '0;
            for (int k = 0; k < DIGITS; k++)
                rd[4*k +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
            bus.digits_i = rd;
            bus.dp_i     = 4'($urandom);
            bus.load_i   = ($urandom % 8) == 0;
            bus.enable_i = ($urandom % 10) != 0;
            if (i % 50 == 0) begin
                bus.blank_lz_i   = 1'($urandom);
                bus.blink_mask_i = 4'($urandom);
            end
            tick();
        end
        bus.load_i = 1'b0; bus.enable_i = 1'b1;
        bus.blink_mask_i = '0; bus.blank_lz_i = 1'b0;

        // 6: asynchronous reset at cyc=5, idx=2
        run_to(25);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        @(posedge clk);
        #1 check_reset("rst_held");
        @(negedge clk);
        n = 0;
        ld_n.delete(); ld_dig.delete(); ld_dp.delete();
        rst_n = 1'b1;
        first_fr = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (first_fr < 0 && bus.frame_o) first_fr = n;
        end
        chk("rst_first_frame", 32'(first_fr), 32'(FRAME));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
